// File: rtl/io_ctrl_pkg.sv
// Shared types and default sizes for the CPU-to-port IO controller.
package io_ctrl_pkg;

    localparam int DEFAULT_DATA_W    = 16;
    localparam int DEFAULT_NUM_PORTS = 4;
    localparam int XFER_CNT_W        = 8;
    localparam int PORT_SEL_W        = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WSTROBE = 3'd1,
        RSTROBE = 3'd2,
        RHOLD   = 3'd3,
        DONE    = 3'd4
    } io_state_t;

endpackage

// File: rtl/io_ctrl_if.sv
// CPU request/response and port bus signals of the IO controller.
interface io_ctrl_if
    import io_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS
);
    logic                  req;
    logic                  wr;
    logic [PORT_SEL_W-1:0] port_sel;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W-1:0]     port_bus;
    logic [DATA_W-1:0]     bus_drv;
    logic [NUM_PORTS-1:0]  io_en;
    logic [NUM_PORTS-1:0]  io_out;
    logic                  ack;
    logic                  busy;
    logic [DATA_W-1:0]     cpu_rdata;
    logic [XFER_CNT_W-1:0] xfer_cnt;

    // The master side is the CPU together with the ports returning data.
    modport master (
        output req, wr, port_sel, cpu_wdata, port_bus,
        input  bus_drv, io_en, io_out, ack, busy, cpu_rdata, xfer_cnt
    );

    modport slave (
        input  req, wr, port_sel, cpu_wdata, port_bus,
        output bus_drv, io_en, io_out, ack, busy, cpu_rdata, xfer_cnt
    );
endinterface

// File: rtl/io_ctrl_sel_dec.sv
// Index-to-one-hot port decoder; all zeros when not enabled.
module io_sel_dec
    import io_ctrl_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS
) (
    input  logic [PORT_SEL_W-1:0] idx,
    input  logic                  en,
    output logic [NUM_PORTS-1:0]  onehot
);
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            onehot[i] = en && (32'(idx) == i);
        end
    end
endmodule

// File: rtl/io_ctrl.sv
// Sequences one CPU transfer at a time onto a shared port bus with per-port strobes.
module io_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS
) (
    input  logic      clk,
    input  logic      reset,
    io_ctrl_if.slave  cpu
);
    io_state_t             state;
    logic [PORT_SEL_W-1:0] sel_q;
    logic [DATA_W-1:0]     bus_drv_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [XFER_CNT_W-1:0] cnt_q;
    logic                  wen_q;
    logic                  ren_q;
    logic                  ack_q;
    logic                  busy_q;

    // Strobe flags are registered alongside the state so every output is a flop
    // or a decode of flops; request inputs only ever reach the IDLE branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel_q     <= '0;
            bus_drv_q <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wen_q     <= 1'b0;
            ack_q     <= 1'b0;
            bus_drv_q <= '0;
            case (state)
                IDLE: begin
                    if (cpu.req) begin
                        sel_q  <= cpu.port_sel;
                        busy_q <= 1'b1;
                        if (cpu.wr) begin
                            state     <= WSTROBE;
                            wen_q     <= 1'b1;
                            bus_drv_q <= cpu.cpu_wdata;
                        end else begin
                            state <= RSTROBE;
                            ren_q <= 1'b1;
                        end
                    end
                end
                WSTROBE: begin
                    state <= DONE;
                    ack_q <= 1'b1;
                end
                RSTROBE: begin
                    state <= RHOLD;
                end
                RHOLD: begin
                    rdata_q <= cpu.port_bus;
                    ren_q   <= 1'b0;
                    ack_q   <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    cnt_q  <= cnt_q + 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    ren_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    io_sel_dec #(.NUM_PORTS(NUM_PORTS)) u_en_dec (
        .idx    (sel_q),
        .en     (wen_q),
        .onehot (cpu.io_en)
    );

    io_sel_dec #(.NUM_PORTS(NUM_PORTS)) u_out_dec (
        .idx    (sel_q),
        .en     (ren_q),
        .onehot (cpu.io_out)
    );

    assign cpu.bus_drv   = bus_drv_q;
    assign cpu.ack       = ack_q;
    assign cpu.busy      = busy_q;
    assign cpu.cpu_rdata = rdata_q;
    assign cpu.xfer_cnt  = cnt_q;
endmodule

// File: tb/tb_io_ctrl.sv
// Directed self-checking bench for io_ctrl with hand-computed expectations.
module tb_io_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   overlap_seen;

    io_ctrl_if #(.DATA_W(16), .NUM_PORTS(4)) bus ();

    io_ctrl #(.DATA_W(16), .NUM_PORTS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watches every cycle for strobes that are not one-hot or that overlap.
    always @(negedge clk) begin
        if (reset === 1'b0 &&
            (($countones(bus.io_en) > 1) || ($countones(bus.io_out) > 1) ||
             (bus.io_en !== 4'b0000 && bus.io_out !== 4'b0000)))
            overlap_seen = overlap_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req       = 1'b0;
        bus.wr        = 1'b0;
        bus.port_sel  = 2'd0;
        bus.cpu_wdata = 16'h0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req = 1'b1;
        bus.wr  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if ({bus.io_en, bus.io_out, bus.ack, bus.busy} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {bus.io_en, bus.io_out, bus.ack, bus.busy});
        end
        checks++;
        if ({bus.bus_drv, bus.cpu_rdata, bus.xfer_cnt} !== 40'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", {bus.bus_drv, bus.cpu_rdata, bus.xfer_cnt});
        end
    endtask

    task automatic test_write();
        bus.req = 1'b1; bus.wr = 1'b1; bus.port_sel = 2'd2; bus.cpu_wdata = 16'hA5C3;
        tick();
        idle_inputs();
        checks++;
        if (bus.io_en !== 4'b0100 || bus.bus_drv !== 16'hA5C3 || bus.ack !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_strobe: got en=%b drv=%h ack=%b busy=%b expected en=0100 drv=a5c3 ack=0 busy=1",
                     bus.io_en, bus.bus_drv, bus.ack, bus.busy);
        end
        tick();
        checks++;
        if (bus.ack !== 1'b1 || bus.io_en !== 4'b0000 || bus.bus_drv !== 16'h0) begin
            errors++;
            $display("[TB] FAIL write_ack: got ack=%b en=%b drv=%h expected ack=1 en=0000 drv=0", bus.ack, bus.io_en, bus.bus_drv);
        end
        tick();
        checks++;
        if (bus.xfer_cnt !== 8'd1 || bus.ack !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_done: got cnt=%0d ack=%b busy=%b expected cnt=1 ack=0 busy=0", bus.xfer_cnt, bus.ack, bus.busy);
        end
    endtask

    task automatic test_read();
        bus.port_bus = 16'h1234;
        bus.req = 1'b1; bus.wr = 1'b0; bus.port_sel = 2'd1;
        tick();
        idle_inputs();
        checks++;
        if (bus.io_out !== 4'b0010 || bus.io_en !== 4'b0000 || bus.ack !== 1'b0 || bus.bus_drv !== 16'h0) begin
            errors++;
            $display("[TB] FAIL read_strobe: got out=%b en=%b ack=%b drv=%h expected out=0010 en=0000 ack=0 drv=0",
                     bus.io_out, bus.io_en, bus.ack, bus.bus_drv);
        end
        tick();
        checks++;
        if (bus.io_out !== 4'b0010 || bus.ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_hold: got out=%b ack=%b expected out=0010 ack=0", bus.io_out, bus.ack);
        end
        tick();
        bus.port_bus = 16'hFFFF;
        checks++;
        if (bus.ack !== 1'b1 || bus.cpu_rdata !== 16'h1234 || bus.io_out !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL read_ack: got ack=%b rdata=%h out=%b expected ack=1 rdata=1234 out=0000",
                     bus.ack, bus.cpu_rdata, bus.io_out);
        end
        tick();
        checks++;
        if (bus.cpu_rdata !== 16'h1234 || bus.xfer_cnt !== 8'd2 || bus.ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_done: got rdata=%h cnt=%0d ack=%b expected rdata=1234 cnt=2 ack=0",
                     bus.cpu_rdata, bus.xfer_cnt, bus.ack);
        end
    endtask

    task automatic test_busy_ignore();
        int acks = 0;
        int en3  = 0;
        bus.req = 1'b1; bus.wr = 1'b1; bus.port_sel = 2'd0; bus.cpu_wdata = 16'h1111;
        tick();
        bus.port_sel = 2'd3; bus.cpu_wdata = 16'hBEEF;
        checks++;
        if (bus.io_en !== 4'b0001 || bus.bus_drv !== 16'h1111) begin
            errors++;
            $display("[TB] FAIL ignore_strobe: got en=%b drv=%h expected en=0001 drv=1111", bus.io_en, bus.bus_drv);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) idle_inputs();
            if (bus.ack === 1'b1) acks++;
            if (bus.io_en[3] === 1'b1) en3++;
        end
        checks++;
        if (acks != 1 || en3 != 0) begin
            errors++;
            $display("[TB] FAIL ignore_queue: got acks=%0d en3=%0d expected acks=1 en3=0", acks, en3);
        end
        checks++;
        if (bus.xfer_cnt !== 8'd3 || bus.cpu_rdata !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL ignore_cnt: got cnt=%0d rdata=%h expected cnt=3 rdata=1234", bus.xfer_cnt, bus.cpu_rdata);
        end
    endtask

    task automatic test_input_change();
        bus.port_bus = 16'h5A5A;
        bus.req = 1'b1; bus.wr = 1'b0; bus.port_sel = 2'd0;
        tick();
        bus.req = 1'b0; bus.wr = 1'b1; bus.port_sel = 2'd3;
        checks++;
        if (bus.io_out !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL change_c1: got out=%b expected 0001", bus.io_out);
        end
        tick();
        checks++;
        if (bus.io_out !== 4'b0001 || bus.io_en !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL change_c2: got out=%b en=%b expected out=0001 en=0000", bus.io_out, bus.io_en);
        end
        tick();
        idle_inputs();
        checks++;
        if (bus.ack !== 1'b1 || bus.cpu_rdata !== 16'h5A5A) begin
            errors++;
            $display("[TB] FAIL change_rdata: got ack=%b rdata=%h expected ack=1 rdata=5a5a", bus.ack, bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int acks = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.port_bus = 16'hABCD;
        bus.req = 1'b1; bus.wr = 1'b0; bus.port_sel = 2'd2;
        tick();
        idle_inputs();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.io_en, bus.io_out, bus.ack, bus.busy} !== 10'b0 ||
            {bus.bus_drv, bus.cpu_rdata, bus.xfer_cnt} !== 40'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outs: got en=%b out=%b ack=%b busy=%b drv=%h rdata=%h cnt=%0d expected all 0",
                     bus.io_en, bus.io_out, bus.ack, bus.busy, bus.bus_drv, bus.cpu_rdata, bus.xfer_cnt);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0 || bus.xfer_cnt !== 8'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_after: got acks=%0d cnt=%0d busy=%b expected 0 0 0", acks, bus.xfer_cnt, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int bad_en = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                checks++;
                if (bus.xfer_cnt !== 8'd255) begin
                    errors++;
                    $display("[TB] FAIL wrap_255: got cnt=%0d expected 255", bus.xfer_cnt);
                end
            end
            bus.req = 1'b1; bus.wr = 1'b1; bus.port_sel = 2'(i); bus.cpu_wdata = 16'(i);
            tick();
            idle_inputs();
            if (bus.io_en !== (4'b0001 << (i % 4)) || bus.bus_drv !== 16'(i)) bad_en++;
            tick();
            if (bus.ack === 1'b1) acks++;
            tick();
        end
        checks++;
        if (bad_en != 0) begin
            errors++;
            $display("[TB] FAIL b2b_strobes: got %0d wrong strobes expected 0", bad_en);
        end
        checks++;
        if (acks != 256 || bus.xfer_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL wrap_cnt: got acks=%0d cnt=%0d expected acks=256 cnt=0", acks, bus.xfer_cnt);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        overlap_seen = 0;
        reset        = 1'b1;
        bus.port_bus = 16'h0;
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_busy_ignore();
        test_input_change();
        test_mid_reset();
        test_back_to_back();
        checks++;
        if (overlap_seen != 0) begin
            errors++;
            $display("[TB] FAIL strobe_onehot: got %0d bad cycles expected 0", overlap_seen);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_ctrl.md
IO_CTRL -- requirements
Module: io_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: width of CPU data and port bus.
REQ-002 Parameter NUM_PORTS, default 4: number of IO ports served; port_sel width is 2.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  CPU transfer request; sampled only in IDLE.
REQ-006 wr  input  1  1 = CPU-to-port write, 0 = port-to-CPU read; sampled with req.
REQ-007 port_sel  input  2  target port index; sampled with req.
REQ-008 cpu_wdata  input  DATA_W  write data; sampled with req.
REQ-009 port_bus  input  DATA_W  shared data returned by the ports' busOUT.
REQ-010 bus_drv  output  DATA_W  data driven onto the ports' shared busIN.
REQ-011 io_en  output  NUM_PORTS  per-port latch enable (IO_EN0..3).
REQ-012 io_out  output  NUM_PORTS  per-port output enable (IO_OUT0..3).
REQ-013 ack  output  1  one-cycle transfer-complete pulse.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 cpu_rdata  output  DATA_W  last captured read data.
REQ-016 xfer_cnt  output  8  count of completed transfers.

Function
REQ-017 States SHALL be IDLE, WSTROBE, RSTROBE, RHOLD, DONE.
REQ-018 IDLE with req=1 SHALL register wr, port_sel and cpu_wdata, then go to WSTROBE if wr=1, otherwise RSTROBE.
REQ-019 IDLE with req=0 SHALL remain in IDLE.
REQ-020 WSTROBE SHALL drive the registered data on bus_drv, set io_en[sel]=1 for exactly one cycle, then go to DONE.
REQ-021 RSTROBE and RHOLD SHALL each hold io_out[sel]=1; RSTROBE goes to RHOLD.
REQ-022 On the clock edge ending RHOLD, port_bus SHALL be captured into cpu_rdata, then the FSM goes to DONE.
REQ-023 DONE SHALL assert ack for one cycle, increment xfer_cnt (255 wraps to 0), then go to IDLE.
REQ-024 Latency from req sampled to ack high SHALL be 2 cycles for a write and 3 cycles for a read; minimum spacing between transfers is 3 cycles (write) and 4 cycles (read).
REQ-025 req asserted outside IDLE SHALL be ignored, not queued.
REQ-026 Changes to port_sel, wr or cpu_wdata after acceptance SHALL have no effect on the transfer in progress.
REQ-027 io_en and io_out SHALL each be one-hot or all-zero, and SHALL never both be non-zero in the same cycle.
REQ-028 bus_drv SHALL be 0 in every state except WSTROBE; no tristate values are generated.
REQ-029 cpu_rdata SHALL hold its value until the next read capture; writes do not change it.
REQ-030 All outputs SHALL be registered or decoded from registered state only; there is no combinational path from req to any output.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, regardless of current state, including mid-transfer.
REQ-032 After that edge: io_en=0, io_out=0, bus_drv=0, ack=0, busy=0, cpu_rdata=0, xfer_cnt=0.
REQ-033 A transfer interrupted by reset SHALL produce no ack and no xfer_cnt increment.
REQ-034 req sampled in the same cycle as reset=1 SHALL be ignored.

Structure
REQ-035 Package io_ctrl_pkg SHALL hold the state enum, DATA_W and NUM_PORTS defaults, and the xfer_cnt width constant.
REQ-036 The one-hot port decoder SHALL be sub-module io_sel_dec: 2-bit index plus enable in, NUM_PORTS one-hot out; it is used for both io_en and io_out.
REQ-037 FSM, data registers and counter SHALL reside in io_ctrl.

Verification
REQ-038 Write test: req=1, wr=1, port_sel=2, cpu_wdata=16'hA5C3 at cycle 0 -> cycle 1: io_en=4'b0100, bus_drv=16'hA5C3; cycle 2: ack=1; xfer_cnt=1.
REQ-039 Read test: port_bus=16'h1234, req=1, wr=0, port_sel=1 at cycle 0 -> io_out=4'b0010 in cycles 1-2; cycle 3: ack=1, cpu_rdata=16'h1234.
REQ-040 Busy-ignore test: second req on port 3 issued in cycle 1 of a write -> no io_en[3] pulse, exactly one ack.
REQ-041 Mid-transfer reset: reset in RHOLD -> next cycle all outputs zero, no ack, xfer_cnt unchanged at 0.
REQ-042 Wrap test: 256 back-to-back writes -> xfer_cnt returns to 0; io_en and io_out never both non-zero.
REQ-043 Input-change test: port_sel changed 0 to 3 in the cycle after a read is accepted -> io_out stays 4'b0001.
